// File: rtl/pp_seq_reducer_pkg.sv
// Shared widths and FSM encoding for the sequential Booth partial-product reducer.
package pp_seq_reducer_pkg;

  localparam int unsigned PARM_MANT = 23;
  localparam int unsigned PARM_PP   = 13;
  localparam int unsigned PP_W      = 2 * PARM_MANT + 3;
  localparam int unsigned PROD_W    = 2 * PARM_MANT + 2;
  localparam int unsigned STEP_W    = 3;

  localparam logic [STEP_W-1:0] LAST_STEP = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COMP = 2'd1,
    ST_ADD  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/pp_seq_reducer_csa42.sv
// Bitwise 4:2 compressor built from two cascaded 3:2 rows; carry is returned already
// aligned to its weight (shifted left by one, top carry dropped), so sum + carry == a+b+c+d mod 2^W.
module csa42_row
  import pp_seq_reducer_pkg::*;
#(
  parameter int unsigned W = PP_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  logic [W-1:0] s1;
  logic [W-1:0] k1;

  assign s1 = a ^ b ^ c;
  assign k1 = {(a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0]), 1'b0};

  assign sum   = s1 ^ k1 ^ d;
  assign carry = {(s1[W-2:0] & k1[W-2:0]) | (s1[W-2:0] & d[W-2:0]) | (k1[W-2:0] & d[W-2:0]), 1'b0};

endmodule

// File: rtl/pp_seq_reducer.sv
// Sequential reducer: folds 13 Booth partial products through one 4:2 row over six
// steps, then a single carry-propagate add yields the 48-bit mantissa product.
module pp_seq_reducer #(
  parameter int unsigned PARM_MANT = pp_seq_reducer_pkg::PARM_MANT,
  parameter int unsigned PARM_PP   = pp_seq_reducer_pkg::PARM_PP
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [2*PARM_MANT+2:0] pp_00_i,
  input  logic [2*PARM_MANT+2:0] pp_01_i,
  input  logic [2*PARM_MANT+2:0] pp_02_i,
  input  logic [2*PARM_MANT+2:0] pp_03_i,
  input  logic [2*PARM_MANT+2:0] pp_04_i,
  input  logic [2*PARM_MANT+2:0] pp_05_i,
  input  logic [2*PARM_MANT+2:0] pp_06_i,
  input  logic [2*PARM_MANT+2:0] pp_07_i,
  input  logic [2*PARM_MANT+2:0] pp_08_i,
  input  logic [2*PARM_MANT+2:0] pp_09_i,
  input  logic [2*PARM_MANT+2:0] pp_10_i,
  input  logic [2*PARM_MANT+2:0] pp_11_i,
  input  logic [2*PARM_MANT+2:0] pp_12_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [2*PARM_MANT+1:0] prod_o
);
  import pp_seq_reducer_pkg::*;

  localparam int unsigned W_PP   = 2 * PARM_MANT + 3;
  localparam int unsigned W_PROD = 2 * PARM_MANT + 2;

  state_e              state_q;
  logic [STEP_W-1:0]   step_q;
  logic [W_PP-1:0]     s_q;
  logic [W_PP-1:0]     c_q;
  logic [W_PP-1:0]     pp_q [PARM_PP];
  logic [W_PROD-1:0]   prod_q;

  logic [W_PP-1:0]     pp_in [PARM_PP];
  logic [W_PP-1:0]     csa_a, csa_b, csa_c, csa_d;
  logic [W_PP-1:0]     csa_sum, csa_carry;

  assign pp_in[0]  = pp_00_i;
  assign pp_in[1]  = pp_01_i;
  assign pp_in[2]  = pp_02_i;
  assign pp_in[3]  = pp_03_i;
  assign pp_in[4]  = pp_04_i;
  assign pp_in[5]  = pp_05_i;
  assign pp_in[6]  = pp_06_i;
  assign pp_in[7]  = pp_07_i;
  assign pp_in[8]  = pp_08_i;
  assign pp_in[9]  = pp_09_i;
  assign pp_in[10] = pp_10_i;
  assign pp_in[11] = pp_11_i;
  assign pp_in[12] = pp_12_i;

  // Compressor operand select: step 0 seeds from pp_00/pp_01, later steps fold in (S, C).
  always_comb begin
    csa_a = s_q;
    csa_b = c_q;
    csa_c = '0;
    csa_d = '0;
    if (step_q == '0) begin
      csa_a = pp_q[0];
      csa_b = pp_q[1];
    end
    case (step_q)
      3'd0:    begin csa_c = pp_q[2];  csa_d = pp_q[3];  end
      3'd1:    begin csa_c = pp_q[4];  csa_d = pp_q[5];  end
      3'd2:    begin csa_c = pp_q[6];  csa_d = pp_q[7];  end
      3'd3:    begin csa_c = pp_q[8];  csa_d = pp_q[9];  end
      3'd4:    begin csa_c = pp_q[10]; csa_d = pp_q[11]; end
      3'd5:    begin csa_c = pp_q[12]; end
      default: ;
    endcase
  end

  csa42_row #(
    .W(W_PP)
  ) u_csa (
    .a    (csa_a),
    .b    (csa_b),
    .c    (csa_c),
    .d    (csa_d),
    .sum  (csa_sum),
    .carry(csa_carry)
  );

  // C holds the carry vector at its true weight, so the final add is simply S + C.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      s_q     <= '0;
      c_q     <= '0;
      prod_q  <= '0;
      for (int unsigned i = 0; i < PARM_PP; i++) pp_q[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid_i) begin
            pp_q    <= pp_in;
            step_q  <= '0;
            state_q <= ST_COMP;
          end
        end
        ST_COMP: begin
          s_q <= csa_sum;
          c_q <= csa_carry;
          if (step_q == LAST_STEP) state_q <= ST_ADD;
          else                     step_q  <= step_q + 3'd1;
        end
        ST_ADD: begin
          prod_q  <= s_q[W_PROD-1:0] + c_q[W_PROD-1:0];
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready_i) state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready_o  = (state_q == ST_IDLE);
  assign out_valid_o = (state_q == ST_DONE);
  assign prod_o      = prod_q;

endmodule

// File: tb/tb_pp_seq_reducer.sv
// Self-checking bench for pp_seq_reducer: builds Booth partial products from A/B,
// scoreboards expected products and checks handshake timing corner cases.
module tb_pp_seq_reducer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [48:0] pp [13];
  logic [47:0] prod;

  int n_vec = 0;
  int n_err = 0;
  logic [47:0] sb [$];

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [47:0] exp;
  } vec_t;
  vec_t tbl [10];

  pp_seq_reducer dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .pp_00_i    (pp[0]),
    .pp_01_i    (pp[1]),
    .pp_02_i    (pp[2]),
    .pp_03_i    (pp[3]),
    .pp_04_i    (pp[4]),
    .pp_05_i    (pp[5]),
    .pp_06_i    (pp[6]),
    .pp_07_i    (pp[7]),
    .pp_08_i    (pp[8]),
    .pp_09_i    (pp[9]),
    .pp_10_i    (pp[10]),
    .pp_11_i    (pp[11]),
    .pp_12_i    (pp[12]),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .prod_o     (prod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Radix-4 Booth rows of d*A, sign bit inverted, with the summed -2^(25+2i) constant folded into pp[0].
  task automatic load_pp(input logic [23:0] a, input logic [23:0] b);
    logic [26:0] bx;
    longint d, row, r26, m, k;
    bx = {2'b00, b, 1'b0};
    k  = 0;
    for (int i = 0; i < 13; i++) begin
      d   = -2 * longint'(bx[2*i+2]) + longint'(bx[2*i+1]) + longint'(bx[2*i]);
      row = d * longint'(a);
      r26 = row & 64'h3FF_FFFF;
      m   = ((((r26 >> 25) & 1) ^ 1) << 25) | (r26 & 64'h1FF_FFFF);
      pp[i] = 49'(m << (2 * i));
      k  += longint'(1) << (25 + 2 * i);
    end
    pp[0] = 49'(longint'(pp[0]) - k);
  endtask

  task automatic scramble_pp();
    for (int i = 0; i < 13; i++) pp[i] = 49'({$urandom(), $urandom()});
  endtask

  // Offer a set; returns one time unit after the accepting edge.
  task automatic send(input logic [23:0] a, input logic [23:0] b, input logic [47:0] exp,
                      input bit keep);
    bit ok;
    ok = 1'b0;
    load_pp(a, b);
    in_valid = 1'b1;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got no accept required accept within 40 cycles");
    end else begin
      sb.push_back(exp);
    end
    if (!keep) begin
      in_valid = 1'b0;
      scramble_pp();
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 60 && sb.size() != 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d outstanding required 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Output monitor: a transfer happens at the posedge following a negedge with valid & ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got prod 0x%0h required no output", prod);
      end else begin
        check("prod", 64'(prod), 64'(sb.pop_front()));
      end
    end
  end

  initial begin
    logic [23:0] ra, rb;
    int acc_edge;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 13; i++) pp[i] = '0;

    tbl[0] = '{24'h800000, 24'h800000, 48'h4000_0000_0000};
    tbl[1] = '{24'hFFFFFF, 24'hFFFFFF, 48'hFFFF_FE00_0001};
    tbl[2] = '{24'h000000, 24'hABCDEF, 48'h0000_0000_0000};
    tbl[3] = '{24'h000001, 24'h000001, 48'h0000_0000_0001};
    tbl[4] = '{24'hFFFFFF, 24'h000001, 48'h0000_00FF_FFFF};
    tbl[5] = '{24'h000002, 24'h7FFFFF, 48'h0000_00FF_FFFE};
    for (int i = 6; i < 10; i++) begin
      ra = 24'($urandom());
      rb = 24'($urandom());
      tbl[i] = '{ra, rb, 48'(longint'(ra) * longint'(rb))};
    end

    // Reset state
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_prod", 64'(prod), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Latency: out_valid must rise exactly after the 7th edge following accept
    send(24'h800000, 24'h800000, 48'h4000_0000_0000, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) check("comp_in_ready", 64'(in_ready), 64'd0);
      if (k == 6) check("lat_valid_early", 64'(out_valid), 64'd0);
      if (k == 7) check("lat_valid", 64'(out_valid), 64'd1);
    end
    wait_drain();

    // Table-driven products
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].exp, 1'b0);
      wait_drain();
    end

    // Back-pressure: DONE holds product for 20 cycles, then returns to IDLE
    out_ready = 1'b0;
    send(24'h123456, 24'h800001, 48'h091A_2B12_3456, 1'b0);
    for (int k = 0; k < 20 && !out_valid; k++) begin
      @(posedge clk);
      #1;
    end
    check("hold_reach_done", 64'(out_valid), 64'd1);
    repeat (20) begin
      @(posedge clk);
      #1;
      check("hold_prod", 64'(prod), 64'h091A_2B12_3456);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_out_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", 64'(in_ready), 64'd1);
    check("release_out_valid", 64'(out_valid), 64'd0);
    wait_drain();

    // Reset during COMP step 3 abandons the set
    send(24'hFFFFFF, 24'hFFFFFF, 48'hFFFF_FE00_0001, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_prod", 64'(prod), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("midrst_idle", 64'(in_ready), 64'd1);
    send(24'h800000, 24'h800000, 48'h4000_0000_0000, 1'b0);
    wait_drain();

    // Back-to-back with in_valid held high: second accept on edge 9 after the first
    ra = 24'hFEDCBA;
    rb = 24'h654321;
    send(24'hFFFFFF, 24'h123456, 48'(longint'(24'hFFFFFF) * longint'(24'h123456)), 1'b1);
    load_pp(ra, rb);
    acc_edge = 0;
    for (int e = 1; e <= 20 && acc_edge == 0; e++) begin
      @(negedge clk);
      if (in_ready) acc_edge = e;
      @(posedge clk);
      #1;
      if (acc_edge != 0) sb.push_back(48'(longint'(ra) * longint'(rb)));
    end
    in_valid = 1'b0;
    scramble_pp();
    check("b2b_accept_edge", 64'(acc_edge), 64'd9);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
